// File: rtl/gate_tb_pkg.sv
// Shared types and constants for the gate stimulus checker: run-state
// encoding, truth tables for the common two-input gates, and a lookup helper.
package gate_tb_pkg;

    // Run state of the sequencer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Expected gate output per vector index v = {b,a}; bit v is the expected x
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    // Index of the last input vector in a run
    localparam logic [1:0] LAST_VEC = 2'd3;

    // Expected gate output for vector v under truth table tt
    function automatic logic expected_bit(input logic [3:0] tt, input logic [1:0] v);
        return tt[v];
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Per-vector hold counter. Counts cycles while the current vector is applied
// and flags the cycle in which the gate output is to be sampled.
module hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    // A zero hold would make the compare point unreachable; clamp the width
    // so the counter is still well formed if the parameter is misconfigured.
    localparam int W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] hold_q;
    logic [W-1:0] hold_d;

    // Next count: restart at zero on clear, otherwise advance by one
    always_comb begin
        hold_d = {W{1'b0}};
        if (clear) begin
            hold_d = {W{1'b0}};
        end else begin
            hold_d = hold_q + ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= {W{1'b0}};
        end else begin
            hold_q <= hold_d;
        end
    end

    assign expire = (hold_q == LAST);

endmodule

// File: rtl/gate_stim_checker.sv
// On-chip stimulus sequencer and checker for a two-input gate. Drives the four
// input vectors 00,10,01,11 in turn, holds each for HOLD_CYCLES cycles, samples
// the gate output at the end of the hold, and records a verdict.
module gate_stim_checker
    import gate_tb_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [3:0] TRUTH       = TT_AND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       x_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    state_e     state_q;
    logic [1:0] v_q;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic [2:0] err_cnt_q;
    logic [3:0] fail_vec_q;

    logic       expire_s;
    logic       timer_clear_d;
    logic       mismatch_d;
    logic [1:0] v_next_d;
    logic       last_vec_d;

    // The hold counter only runs while a vector is applied, and restarts for
    // every new vector; in IDLE/DONE it is parked at zero so a run starts clean.
    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear_d),
        .expire(expire_s)
    );

    // Decode helpers: compare result, next vector index, end-of-run, timer clear
    always_comb begin
        mismatch_d    = 1'b0;
        v_next_d      = 2'd0;
        last_vec_d    = 1'b0;
        timer_clear_d = 1'b1;
        mismatch_d    = (x_in != expected_bit(TRUTH, v_q));
        v_next_d      = v_q + 2'd1;
        last_vec_d    = (v_q == LAST_VEC);
        if (state_q == DRIVE) begin
            timer_clear_d = expire_s;
        end else begin
            timer_clear_d = 1'b1;
        end
    end

    // Run FSM with registered stimulus, status and verdict outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            v_q        <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_cnt_q  <= 3'd0;
            fail_vec_q <= 4'd0;
        end else begin
            case (state_q)
                // IDLE and DONE accept a start identically; DONE additionally
                // keeps the previous verdict visible until that happens.
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= DRIVE;
                        v_q        <= 2'd0;
                        a_q        <= 1'b0;
                        b_q        <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_cnt_q  <= 3'd0;
                        fail_vec_q <= 4'd0;
                    end
                end
                // Hold the current vector; at the end of its hold, check the gate
                // and either move to the next vector or finish the run.
                DRIVE: begin
                    if (expire_s) begin
                        if (mismatch_d) begin
                            err_cnt_q       <= err_cnt_q + 3'd1;
                            fail_vec_q[v_q] <= 1'b1;
                        end
                        if (last_vec_d) begin
                            state_q <= DONE;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            v_q <= v_next_d;
                            a_q <= v_next_d[0];
                            b_q <= v_next_d[1];
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    v_q        <= 2'd0;
                    a_q        <= 1'b0;
                    b_q        <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    err_cnt_q  <= 3'd0;
                    fail_vec_q <= 4'd0;
                end
            endcase
        end
    end

    assign a_out    = a_q;
    assign b_out    = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vec = fail_vec_q;
    // The verdict is only meaningful once a run has completed
    assign pass     = done_q && (err_cnt_q == 3'd0);

endmodule

// File: tb/tb_gate_stim_checker.sv
// Randomised self-checking bench for gate_stim_checker. Two instances are
// built: HOLD_CYCLES=4 checking AND, and HOLD_CYCLES=1 checking XOR. The gate
// under test is modelled as a 4-entry lookup table; expectations come from
// the run schedule arithmetic (vector = cycle / hold) and the table XOR.
module tb_gate_stim_checker;
    import gate_tb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s = 1'b0;
    logic       sel_s = 1'b0;
    logic [3:0] gate_tt = TT_AND;

    logic       start0, x0, a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fail0;
    logic       start1, x1, a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fail1;

    logic       a_o, b_o, busy_o, done_o, pass_o;
    logic [2:0] err_o;
    logic [3:0] fail_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign start0 = start_s & ~sel_s;
    assign start1 = start_s & sel_s;
    assign x0 = gate_tt[{b0, a0}];
    assign x1 = gate_tt[{b1, a1}];

    assign a_o    = sel_s ? a1    : a0;
    assign b_o    = sel_s ? b1    : b0;
    assign busy_o = sel_s ? busy1 : busy0;
    assign done_o = sel_s ? done1 : done0;
    assign pass_o = sel_s ? pass1 : pass0;
    assign err_o  = sel_s ? err1  : err0;
    assign fail_o = sel_s ? fail1 : fail0;

    gate_stim_checker #(.HOLD_CYCLES(4), .TRUTH(TT_AND)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .x_in(x0),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_vec(fail0)
    );

    gate_stim_checker #(.HOLD_CYCLES(1), .TRUTH(TT_XOR)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x_in(x1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_vec(fail1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " a"},    32'(a_o),    32'd0);
        check_eq({tag, " b"},    32'(b_o),    32'd0);
        check_eq({tag, " busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, " done"}, 32'(done_o), 32'd0);
        check_eq({tag, " pass"}, 32'(pass_o), 32'd0);
        check_eq({tag, " err"},  32'(err_o),  32'd0);
        check_eq({tag, " fail"}, 32'(fail_o), 32'd0);
    endtask

    // One complete run against gate table gtt. poke: random start activity
    // (including pulses 3 and 9 cycles in) which must be ignored. keep_start:
    // leave start high at the end for a back-to-back run.
    task automatic run_one(input string tag, input logic [3:0] gtt, input bit poke, input bit keep_start);
        int         h;
        logic [3:0] tt;
        logic [3:0] mism;
        logic [3:0] exp_fail;
        int         exp_err;
        int         vec;
        h    = sel_s ? 1 : 4;
        tt   = sel_s ? TT_XOR : TT_AND;
        gate_tt = gtt;
        mism = gtt ^ tt;
        start_s = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 4 * h; j++) begin
            vec = j / h;
            exp_err  = 0;
            exp_fail = 4'd0;
            for (int n = 0; n < 4; n++) begin
                if (((n + 1) * h <= j) && mism[n]) begin
                    exp_err++;
                    exp_fail[n] = 1'b1;
                end
            end
            check_eq({tag, " a"},    32'(a_o),    32'(vec % 2));
            check_eq({tag, " b"},    32'(b_o),    32'(vec / 2));
            check_eq({tag, " busy"}, 32'(busy_o), 32'd1);
            check_eq({tag, " done"}, 32'(done_o), 32'd0);
            check_eq({tag, " pass"}, 32'(pass_o), 32'd0);
            check_eq({tag, " err"},  32'(err_o),  32'(exp_err));
            check_eq({tag, " fail"}, 32'(fail_o), 32'(exp_fail));
            if (keep_start) begin
                start_s = 1'b1;
            end else if (poke) begin
                start_s = (j == 2 || j == 8) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                start_s = 1'b0;
            end
            @(posedge clk); #1;
        end
        check_eq({tag, " end a"},    32'(a_o),    32'd0);
        check_eq({tag, " end b"},    32'(b_o),    32'd0);
        check_eq({tag, " end busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, " end done"}, 32'(done_o), 32'd1);
        check_eq({tag, " end err"},  32'(err_o),  32'($countones(mism)));
        check_eq({tag, " end fail"}, 32'(fail_o), 32'(mism));
        check_eq({tag, " end pass"}, 32'(pass_o), 32'(mism == 4'd0));
        if (!keep_start) begin
            start_s = 1'b0;
        end
    endtask

    initial begin
        // Reset state of both instances
        #12;
        sel_s = 1'b0;
        check_idle_outputs("reset dut0");
        sel_s = 1'b1;
        check_idle_outputs("reset dut1");
        sel_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Correct AND with start pulses during the run
        run_one("and_ok", TT_AND, 1'b1, 1'b0);
        // Verdict holds in DONE without a new start
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_hold done", 32'(done_o), 32'd1);
        check_eq("done_hold pass", 32'(pass_o), 32'd1);
        check_eq("done_hold err",  32'(err_o),  32'd0);

        // Restart from DONE: stuck-at-0 output, then OR connected
        run_one("stuck0", 4'b0000, 1'b0, 1'b0);
        run_one("or_gate", TT_OR, 1'b1, 1'b0);

        // Reset in the middle of a run
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("after_reset busy", 32'(busy_o), 32'd0);
        check_eq("after_reset done", 32'(done_o), 32'd0);
        run_one("post_reset", TT_AND, 1'b0, 1'b0);

        // start held high: back-to-back runs, done high for one cycle
        run_one("b2b_first", TT_NAND, 1'b0, 1'b1);
        run_one("b2b_second", TT_AND, 1'b0, 1'b0);

        // Random gate tables at HOLD_CYCLES=4
        for (int r = 0; r < 6; r++) begin
            run_one("rand_h4", 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // HOLD_CYCLES=1 instance checking XOR
        sel_s = 1'b1;
        #1;
        check_idle_outputs("h1_idle");
        run_one("xor_ok", TT_XOR, 1'b0, 1'b0);
        run_one("h1_nor", TT_NOR, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_one("rand_h1", 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: got=running expected=finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
